multicycle_sequencer: RTL and testbench

//  Parametrised top-level sequencer for the multicycle MIPS core: fetch with configurable memory latency, decode into instruction classes, and dispatch to per-class execution sub-FSMs.

---
 rtl/multicycle_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_sequencer                                         |
// | Description : Top-level control sequencer for the multicycle MIPS core.    |
// |               Fetches with a configurable memory latency, decodes into     |
// |               instruction classes and dispatches to per-class execution    |
// |               sub-FSMs. It also runs the mult/div start/done handshake     |
// |               with a timeout and sequences exceptions (invalid opcode,     |
// |               overflow, divide-by-zero) through EPC save and vector fetch. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in   1  core clock, rising edge                             |
// |   rst_n        in   1  asynchronous active-low reset                       |
// |   opcode_i     in   6  IR[31:26]                                           |
// |   funct_i      in   6  IR[5:0]                                             |
// |   ovf_i        in   1  ALU overflow, sampled on the exec_done cycle        |
// |   divzero_i    in   1  divisor == 0, sampled in MD_ISSUE                   |
// |   exec_done_i  in   1  class sub-FSM finished (pulse)                      |
// |   md_done_i    in   1  mult/div result ready (pulse)                       |
// |   reset_out_o  out  1  register-bank/stack reset request                   |
// |   pc_write_o   out  1  PC load enable                                      |
// |   pc_src_o     out  2  00 PC+4, 10 vector byte from memory                 |
// |   ir_write_o   out  1  IR load enable                                      |
// |   ab_write_o   out  1  A/B register load enable                            |
// |   iord_o       out  2  memory address select: 00 PC, 10 exception vector   |
// |   exec_go_o    out  1  start pulse to the class sub-FSM                    |
// |   iclass_o     out  3  decoded class, held from decode until next fetch    |
// |   md_start_o   out  1  start pulse to the mult/div unit                    |
// |   md_timeout_o out  1  sticky: mult/div unit never answered               |
// |   epc_write_o  out  1  EPC load enable                                     |
// |   exc_code_o   out  2  0 invalid, 1 overflow, 2 divide-by-zero             |
// |   state_o      out  4  current state (debug)                               |
// +----------------------------------------------------------------------------+
module multicycle_sequencer #(
  parameter int MEM_LAT    = 2,
  parameter int MD_TIMEOUT = 40,
  parameter int VEC_BASE   = 253
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       ovf_i,
  input  logic       divzero_i,
  input  logic       exec_done_i,
  input  logic       md_done_i,
  output logic       reset_out_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       ab_write_o,
  output logic [1:0] iord_o,
  output logic       exec_go_o,
  output logic [2:0] iclass_o,
  output logic       md_start_o,
  output logic       md_timeout_o,
  output logic       epc_write_o,
  output logic [1:0] exc_code_o,
  output logic [3:0] state_o
);

  // The three vectors live at VEC_BASE..VEC_BASE+2 and must stay byte-addressable.
  if (MEM_LAT < 1 || MD_TIMEOUT < 1 || VEC_BASE < 0 || VEC_BASE > 253) begin : g_param_check
    $error("multicycle_sequencer: illegal parameter value");
  end

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_RST        = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_FETCH_IR   = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MD_ISSUE   = 4'd5,
    S_MD_WAIT    = 4'd6,
    S_EXC_EPC    = 4'd7,
    S_EXC_VEC    = 4'd8,
    S_EXC_LOAD   = 4'd9
  } state_e;

  localparam logic [2:0] c_cls_r_alu   = 3'd0;
  localparam logic [2:0] c_cls_imm     = 3'd1;
  localparam logic [2:0] c_cls_branch  = 3'd2;
  localparam logic [2:0] c_cls_mem     = 3'd3;
  localparam logic [2:0] c_cls_jump    = 3'd4;
  localparam logic [2:0] c_cls_muldiv  = 3'd5;
  localparam logic [2:0] c_cls_invalid = 3'd6;

  localparam logic [1:0] c_exc_invalid = 2'd0;
  localparam logic [1:0] c_exc_ovf     = 2'd1;
  localparam logic [1:0] c_exc_divzero = 2'd2;

  localparam logic [1:0] c_pc_src_alu = 2'b00;
  localparam logic [1:0] c_pc_src_vec = 2'b10;
  localparam logic [1:0] c_iord_pc    = 2'b00;
  localparam logic [1:0] c_iord_vec   = 2'b10;

  // Opcodes
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_sram  = 6'h01;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_ble   = 6'h06;
  localparam logic [5:0] c_op_bgt   = 6'h07;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0a;
  localparam logic [5:0] c_op_lui   = 6'h0f;
  localparam logic [5:0] c_op_lb    = 6'h20;
  localparam logic [5:0] c_op_lh    = 6'h21;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sb    = 6'h28;
  localparam logic [5:0] c_op_sh    = 6'h29;
  localparam logic [5:0] c_op_sw    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_srl   = 6'h02;
  localparam logic [5:0] c_fn_sra   = 6'h03;
  localparam logic [5:0] c_fn_sllv  = 6'h04;
  localparam logic [5:0] c_fn_xchg  = 6'h05;
  localparam logic [5:0] c_fn_srav  = 6'h07;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_break = 6'h0d;
  localparam logic [5:0] c_fn_mfhi  = 6'h10;
  localparam logic [5:0] c_fn_mflo  = 6'h12;
  localparam logic [5:0] c_fn_rte   = 6'h13;
  localparam logic [5:0] c_fn_mult  = 6'h18;
  localparam logic [5:0] c_fn_div   = 6'h1a;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_slt   = 6'h2a;

  // One counter serves both the memory-latency waits and the mult/div timeout.
  localparam int c_cnt_max = (MEM_LAT > MD_TIMEOUT) ? MEM_LAT : MD_TIMEOUT;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_lat_last = c_cnt_w'(MEM_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_md_last  = c_cnt_w'(MD_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 reset_out_q, reset_out_d;
  logic                 pc_write_q, pc_write_d;
  logic [1:0]           pc_src_q, pc_src_d;
  logic                 ir_write_q, ir_write_d;
  logic                 ab_write_q, ab_write_d;
  logic [1:0]           iord_q, iord_d;
  logic                 exec_go_q, exec_go_d;
  logic [2:0]           iclass_q, iclass_d;
  logic                 md_start_q, md_start_d;
  logic                 md_timeout_q, md_timeout_d;
  logic                 epc_write_q, epc_write_d;
  logic [1:0]           exc_code_q, exc_code_d;

  logic [2:0]           w_cls;
  logic                 w_ovf_trap;
  logic                 w_div_by_zero;
  logic                 w_md_expired;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cls = c_cls_invalid;
    if (opcode_i == c_op_rtype) begin
      case (funct_i)
        c_fn_add, c_fn_and, c_fn_sub, c_fn_slt, c_fn_sll, c_fn_sllv, c_fn_sra,
        c_fn_srav, c_fn_srl, c_fn_jr, c_fn_mfhi, c_fn_mflo, c_fn_break,
        c_fn_rte, c_fn_xchg:           w_cls = c_cls_r_alu;
        c_fn_div, c_fn_mult:           w_cls = c_cls_muldiv;
        default:                       w_cls = c_cls_invalid;
      endcase
    end else begin
      case (opcode_i)
        c_op_addi, c_op_addiu, c_op_slti, c_op_lui, c_op_sram:
                                       w_cls = c_cls_imm;
        c_op_beq, c_op_bne, c_op_ble, c_op_bgt:
                                       w_cls = c_cls_branch;
        c_op_lb, c_op_lh, c_op_lw, c_op_sb, c_op_sh, c_op_sw:
                                       w_cls = c_cls_mem;
        c_op_j, c_op_jal:              w_cls = c_cls_jump;
        default:                       w_cls = c_cls_invalid;
      endcase
    end
  end

  // Only signed add/sub/addi trap on overflow; addiu and everything else ignore ovf.
  assign w_ovf_trap = ovf_i &&
                      (((opcode_i == c_op_rtype) && ((funct_i == c_fn_add) || (funct_i == c_fn_sub))) ||
                       (opcode_i == c_op_addi));

  // mult never traps on a zero operand.
  assign w_div_by_zero = divzero_i && (funct_i == c_fn_div);

  // ---------------------------------------------------------------------------
  // Next state and next (registered) outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    iclass_d      = iclass_q;
    exc_code_d    = exc_code_q;
    md_timeout_d  = md_timeout_q;
    exec_go_d     = 1'b0;
    md_start_d    = 1'b0;
    reset_out_d   = 1'b0;
    pc_write_d    = 1'b0;
    pc_src_d      = c_pc_src_alu;
    ir_write_d    = 1'b0;
    ab_write_d    = 1'b0;
    iord_d        = c_iord_pc;
    epc_write_d   = 1'b0;
    w_md_expired  = 1'b0;

    case (state_q)
      S_RST: begin
        state_d = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        if (cnt_q == c_lat_last) begin
          state_d = S_FETCH_IR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_FETCH_IR: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        iclass_d = w_cls;
        if (w_cls == c_cls_invalid) begin
          state_d    = S_EXC_EPC;
          exc_code_d = c_exc_invalid;
        end else if (w_cls == c_cls_muldiv) begin
          state_d = S_MD_ISSUE;
        end else begin
          state_d   = S_EXEC;
          exec_go_d = 1'b1;
        end
      end

      S_EXEC: begin
        // Overflow takes priority over normal completion.
        if (exec_done_i) begin
          if (w_ovf_trap) begin
            state_d    = S_EXC_EPC;
            exc_code_d = c_exc_ovf;
          end else begin
            state_d = S_FETCH_WAIT;
          end
        end
      end

      S_MD_ISSUE: begin
        if (w_div_by_zero) begin
          state_d    = S_EXC_EPC;
          exc_code_d = c_exc_divzero;
        end else begin
          state_d    = S_MD_WAIT;
          md_start_d = 1'b1;
          cnt_d      = '0;
        end
      end

      S_MD_WAIT: begin
        // A done arriving on the last allowed cycle still counts as done.
        if (md_done_i) begin
          state_d = S_FETCH_WAIT;
        end else if (cnt_q == c_md_last) begin
          state_d      = S_FETCH_WAIT;
          w_md_expired = 1'b1;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_EXC_EPC: begin
        state_d = S_EXC_VEC;
        cnt_d   = '0;
      end

      S_EXC_VEC: begin
        if (cnt_q == c_lat_last) begin
          state_d = S_EXC_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_EXC_LOAD: begin
        state_d = S_FETCH_WAIT;
      end

      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase

    // Starting a new fetch drops the per-instruction context. md_timeout is
    // raised on the fetch that follows an expired wait and stays up for that
    // whole instruction; any other fetch entry clears it.
    if ((state_d == S_FETCH_WAIT) && (state_q != S_FETCH_WAIT)) begin
      cnt_d        = '0;
      iclass_d     = '0;
      exc_code_d   = '0;
      md_timeout_d = w_md_expired;
    end

    // Level outputs follow the state being entered so they line up with it.
    case (state_d)
      S_RST:        reset_out_d = 1'b1;
      S_FETCH_IR: begin
        ir_write_d = 1'b1;
        pc_write_d = 1'b1;
        pc_src_d   = c_pc_src_alu;
      end
      S_DECODE:     ab_write_d  = 1'b1;
      S_EXC_EPC:    epc_write_d = 1'b1;
      S_EXC_VEC:    iord_d      = c_iord_vec;
      S_EXC_LOAD: begin
        iord_d     = c_iord_vec;
        pc_write_d = 1'b1;
        pc_src_d   = c_pc_src_vec;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      cnt_q        <= '0;
      reset_out_q  <= 1'b1;
      pc_write_q   <= 1'b0;
      pc_src_q     <= '0;
      ir_write_q   <= 1'b0;
      ab_write_q   <= 1'b0;
      iord_q       <= '0;
      exec_go_q    <= 1'b0;
      iclass_q     <= '0;
      md_start_q   <= 1'b0;
      md_timeout_q <= 1'b0;
      epc_write_q  <= 1'b0;
      exc_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reset_out_q  <= reset_out_d;
      pc_write_q   <= pc_write_d;
      pc_src_q     <= pc_src_d;
      ir_write_q   <= ir_write_d;
      ab_write_q   <= ab_write_d;
      iord_q       <= iord_d;
      exec_go_q    <= exec_go_d;
      iclass_q     <= iclass_d;
      md_start_q   <= md_start_d;
      md_timeout_q <= md_timeout_d;
      epc_write_q  <= epc_write_d;
      exc_code_q   <= exc_code_d;
    end
  end

  assign reset_out_o  = reset_out_q;
  assign pc_write_o   = pc_write_q;
  assign pc_src_o     = pc_src_q;
  assign ir_write_o   = ir_write_q;
  assign ab_write_o   = ab_write_q;
  assign iord_o       = iord_q;
  assign exec_go_o    = exec_go_q;
  assign iclass_o     = iclass_q;
  assign md_start_o   = md_start_q;
  assign md_timeout_o = md_timeout_q;
  assign epc_write_o  = epc_write_q;
  assign exc_code_o   = exc_code_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_sequencer                                      |
// | Description : Self-checking bench for multicycle_sequencer. A reference    |
// |               model expands each instruction into its expected per-cycle   |
// |               output trace (fetch, decode, class execution, exception      |
// |               sequence) and every cycle is compared against the DUT.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_sequencer;

  localparam int MEM_LAT    = 2;
  localparam int MD_TIMEOUT = 40;
  localparam int VEC_BASE   = 253;

  localparam logic [5:0] c_f_add   = 6'h20;
  localparam logic [5:0] c_f_sub   = 6'h22;
  localparam logic [5:0] c_f_jr    = 6'h08;
  localparam logic [5:0] c_f_mult  = 6'h18;
  localparam logic [5:0] c_f_div   = 6'h1a;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_beq   = 6'h04;

  typedef struct packed {
    logic       reset_out;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       ab_write;
    logic [1:0] iord;
    logic       exec_go;
    logic [2:0] iclass;
    logic       md_start;
    logic       md_timeout;
    logic       epc_write;
    logic [1:0] exc_code;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_i, funct_i;
  logic       ovf_i, divzero_i, exec_done_i, md_done_i;
  logic       reset_out_o, pc_write_o, ir_write_o, ab_write_o, exec_go_o;
  logic       md_start_o, md_timeout_o, epc_write_o;
  logic [1:0] pc_src_o, iord_o, exc_code_o;
  logic [2:0] iclass_o;
  logic [3:0] state_o;

  int   checks = 0;
  int   errors = 0;
  logic to_flag = 1'b0;   // model: md_timeout expected for the current instruction

  // Instruction tables of the ISA, grouped by class.
  logic [5:0] r_functs  [$] = '{6'h20, 6'h24, 6'h22, 6'h2a, 6'h00, 6'h04, 6'h03, 6'h07,
                                6'h02, 6'h08, 6'h10, 6'h12, 6'h0d, 6'h13, 6'h05};
  logic [5:0] md_functs [$] = '{6'h1a, 6'h18};
  logic [5:0] imm_ops   [$] = '{6'h08, 6'h09, 6'h0a, 6'h0f, 6'h01};
  logic [5:0] br_ops    [$] = '{6'h04, 6'h05, 6'h06, 6'h07};
  logic [5:0] mem_ops   [$] = '{6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b};
  logic [5:0] jmp_ops   [$] = '{6'h02, 6'h03};

  outs_t obs;
  assign obs = {reset_out_o, pc_write_o, pc_src_o, ir_write_o, ab_write_o, iord_o,
                exec_go_o, iclass_o, md_start_o, md_timeout_o, epc_write_o, exc_code_o};

  multicycle_sequencer #(
    .MEM_LAT    (MEM_LAT),
    .MD_TIMEOUT (MD_TIMEOUT),
    .VEC_BASE   (VEC_BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode_i),
    .funct_i      (funct_i),
    .ovf_i        (ovf_i),
    .divzero_i    (divzero_i),
    .exec_done_i  (exec_done_i),
    .md_done_i    (md_done_i),
    .reset_out_o  (reset_out_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .ir_write_o   (ir_write_o),
    .ab_write_o   (ab_write_o),
    .iord_o       (iord_o),
    .exec_go_o    (exec_go_o),
    .iclass_o     (iclass_o),
    .md_start_o   (md_start_o),
    .md_timeout_o (md_timeout_o),
    .epc_write_o  (epc_write_o),
    .exc_code_o   (exc_code_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic int in_list(input logic [5:0] v, input logic [5:0] lst [$]);
    foreach (lst[i]) if (lst[i] == v) return 1;
    return 0;
  endfunction

  function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (in_list(fn, r_functs) != 0)  return 0;
      if (in_list(fn, md_functs) != 0) return 5;
      return 6;
    end
    if (in_list(op, imm_ops) != 0) return 1;
    if (in_list(op, br_ops) != 0)  return 2;
    if (in_list(op, mem_ops) != 0) return 3;
    if (in_list(op, jmp_ops) != 0) return 4;
    return 6;
  endfunction

  function automatic logic ovf_traps(input logic [5:0] op, input logic [5:0] fn);
    return ((op == 6'h00) && ((fn == c_f_add) || (fn == c_f_sub))) || (op == c_op_addi);
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic outs_t base();
    outs_t e;
    e = '0;
    e.md_timeout = to_flag;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and cycle stepping (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input outs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input string tag, input outs_t exp, input logic ed, input logic md,
                      input logic ov, input logic dz);
    chk(tag, exp);
    exec_done_i = ed;
    md_done_i   = md;
    ovf_i       = ov;
    divzero_i   = dz;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    outs_t e;
    e = '0;
    e.reset_out = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("reset_async", e);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", e);
    end
    rst_n   = 1'b1;
    to_flag = 1'b0;
    step("reset_release", e, rb(), rb(), rb(), rb());
  endtask

  task automatic take_exception(input logic [2:0] cls, input logic [1:0] code);
    outs_t e;
    int    vec;
    e = base(); e.iclass = cls; e.exc_code = code; e.epc_write = 1'b1;
    step("exc_epc", e, rb(), rb(), rb(), rb());
    for (int i = 0; i < MEM_LAT; i++) begin
      e = base(); e.iclass = cls; e.exc_code = code; e.iord = 2'b10;
      step("exc_vec", e, rb(), rb(), rb(), rb());
    end
    e = base(); e.iclass = cls; e.exc_code = code; e.iord = 2'b10;
    e.pc_write = 1'b1; e.pc_src = 2'b10;
    // Vector byte address the memory sees in this cycle.
    vec = VEC_BASE + int'(exc_code_o);
    checks++;
    assert (vec == VEC_BASE + int'(code)) else begin
      errors++;
      $error("FAIL vec_addr observed=%0d expected=%0d", vec, VEC_BASE + int'(code));
    end
    step("exc_load", e, rb(), rb(), rb(), rb());
  endtask

  // One instruction from first fetch cycle back to the next fetch.
  // md_lat < 0: mult/div never answers. abort_k >= 0: reset at that MD_WAIT cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int exec_lat,
                           input logic ov, input logic dz, input int md_lat, input int abort_k);
    int    cls;
    logic  timed;
    outs_t e;
    cls   = ref_class(op, fn);
    timed = 1'b0;
    opcode_i = op;
    funct_i  = fn;
    for (int i = 0; i < MEM_LAT; i++) begin
      e = base();
      step("fetch_wait", e, rb(), rb(), rb(), rb());
    end
    e = base(); e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("fetch_ir", e, rb(), rb(), rb(), rb());
    e = base(); e.ab_write = 1'b1;
    step("decode", e, rb(), rb(), rb(), rb());
    if (cls == 6) begin
      take_exception(3'd6, 2'd0);
    end else if (cls == 5) begin
      e = base(); e.iclass = 3'd5;
      step("md_issue", e, rb(), rb(), rb(), dz);
      if ((fn == c_f_div) && dz) begin
        take_exception(3'd5, 2'd2);
      end else begin
        for (int k = 0; k < MD_TIMEOUT; k++) begin
          if (k == abort_k) begin
            do_reset();
            return;
          end
          e = base(); e.iclass = 3'd5; e.md_start = (k == 0);
          step("md_wait", e, rb(), logic'(k == md_lat), rb(), rb());
          if (k == md_lat) break;
          if (k == MD_TIMEOUT - 1) timed = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k <= exec_lat; k++) begin
        e = base(); e.iclass = cls[2:0]; e.exec_go = (k == 0);
        if (k == exec_lat) step("exec_done", e, 1'b1, rb(), ov, rb());
        else               step("exec_wait", e, 1'b0, rb(), rb(), rb());
      end
      if (ov && ovf_traps(op, fn)) take_exception(cls[2:0], 2'd1);
    end
    to_flag = timed;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [5:0] all_ops [$];
    logic [5:0] op, fn;
    int         sel, md_lat;

    all_ops = {imm_ops, br_ops, mem_ops, jmp_ops};
    rst_n = 1'b0; opcode_i = '0; funct_i = '0;
    ovf_i = 1'b0; divzero_i = 1'b0; exec_done_i = 1'b0; md_done_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed cases
    run_instr(6'h00, c_f_add, 0, 1'b1, 1'b0, 0, -1);           // add + ovf -> overflow exception
    run_instr(c_op_addiu, 6'h11, 2, 1'b1, 1'b0, 0, -1);        // addiu ignores ovf
    run_instr(6'h3f, 6'h2a, 0, 1'b0, 1'b0, 0, -1);             // invalid opcode
    run_instr(6'h00, 6'h3f, 0, 1'b0, 1'b0, 0, -1);             // invalid R funct
    run_instr(6'h00, c_f_div, 0, 1'b0, 1'b1, 0, -1);           // div by zero
    run_instr(6'h00, c_f_div, 0, 1'b0, 1'b0, -1, -1);          // mult/div never answers
    run_instr(c_op_beq, 6'h00, 1, 1'b0, 1'b0, 0, -1);          // md_timeout still visible
    run_instr(6'h00, c_f_mult, 0, 1'b0, 1'b1, MD_TIMEOUT - 1, -1); // done on last cycle
    run_instr(6'h00, c_f_sub, 3, 1'b1, 1'b0, 0, -1);           // sub + ovf
    run_instr(c_op_addi, 6'h00, 1, 1'b1, 1'b0, 0, -1);         // addi + ovf
    run_instr(6'h00, c_f_jr, 0, 1'b1, 1'b0, 0, -1);            // jr ignores ovf
    run_instr(6'h00, c_f_mult, 0, 1'b0, 1'b0, 20, 5);          // reset mid MD_WAIT
    run_instr(6'h00, c_f_mult, 0, 1'b0, 1'b0, 3, -1);          // normal mult after reset

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2) begin
        op = 6'h00;
        fn = rb() ? r_functs[$urandom_range(0, r_functs.size() - 1)] : 6'($urandom_range(0, 63));
      end else if (sel <= 4) begin
        op = 6'h00;
        fn = rb() ? c_f_div : c_f_mult;
      end else if (sel <= 8) begin
        op = all_ops[$urandom_range(0, all_ops.size() - 1)];
        fn = 6'($urandom_range(0, 63));
      end else begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end
      md_lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
      run_instr(op, fn, int'($urandom_range(0, 3)), rb(), rb(), md_lat, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire
